// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg : shared segment codes and sizing helper for seg_disp_ctrl
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  // Active-low a..g codes (bit0 = a, bit6 = g)
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DP_BIT = 7;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_digit_dec.sv
// ---------------------------------------------------------------------------
// seg_digit_dec : nibble/blank/dp to 8-bit active-low segment code
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg_digit_dec
  import seg_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] code_o
);

  logic [6:0] w_seg;
  logic [6:0] w_hex;

  always_comb begin
    w_hex = SEG_BLANK;
    case (nibble_i)
      4'hA:    w_hex = SEG_A;
      4'hB:    w_hex = SEG_B;
      4'hC:    w_hex = SEG_C;
      4'hD:    w_hex = SEG_D;
      4'hE:    w_hex = SEG_E;
      default: w_hex = SEG_F;
    endcase
  end

  always_comb begin
    w_seg = SEG_BLANK;
    case (nibble_i)
      4'd0:    w_seg = SEG_0;
      4'd1:    w_seg = SEG_1;
      4'd2:    w_seg = SEG_2;
      4'd3:    w_seg = SEG_3;
      4'd4:    w_seg = SEG_4;
      4'd5:    w_seg = SEG_5;
      4'd6:    w_seg = SEG_6;
      4'd7:    w_seg = SEG_7;
      4'd8:    w_seg = SEG_8;
      4'd9:    w_seg = SEG_9;
      default: w_seg = (HEX_MODE != 0) ? w_hex : SEG_BLANK;
    endcase
  end

  // A blanked digit still carries its decimal point
  always_comb begin
    code_o         = {1'b1, SEG_BLANK};
    code_o[6:0]    = blank_i ? SEG_BLANK : w_seg;
    code_o[DP_BIT] = ~dp_i;
  end

endmodule

`default_nettype wire

// File: rtl/seg_disp_ctrl.sv
// ---------------------------------------------------------------------------
// seg_disp_ctrl : multiplexed 7-segment controller with frame-aligned commit
// Optional blinking is built only when SEG_BLINK_EN is defined.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int HEX_MODE     = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_data,
  output logic                    frame_start
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int DW = idx_width(SCAN_DIV);

  logic [DW-1:0] div_q;
  logic [IW-1:0] idx_q;
  logic          w_div_tc;
  logic          w_frame_end;
  logic          w_xfer;
  logic          w_commit;

  logic [4*NUM_DIGITS-1:0] pend_nib_q, pend_nib_d, act_nib_q, act_nib_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic                    pend_lz_q, pend_lz_d;
  logic                    pend_full_q, pend_full_d;

  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic                    w_lz_run;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic                    w_hide;
  logic [7:0]              w_code;

  logic [NUM_DIGITS-1:0]   seg_sel_q;
  logic [7:0]              seg_data_q;
  logic                    frame_start_q;

  assign w_div_tc    = (div_q == DW'(SCAN_DIV - 1));
  assign w_frame_end = w_div_tc && (idx_q == IW'(NUM_DIGITS - 1));
  assign w_xfer      = upd_valid && !pend_full_q;
  assign w_commit    = w_frame_end && pend_full_q;
  assign upd_ready   = !pend_full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (w_div_tc) begin
      div_q <= '0;
      idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Leading zeros stop at the first non-zero nibble or lit dp; last digit always shown
  always_comb begin
    w_lz_mask = '0;
    w_lz_run  = pend_lz_q;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      if (w_lz_run && (pend_nib_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0) && !pend_dp_q[i])
        w_lz_mask[i] = 1'b1;
      else
        w_lz_run = 1'b0;
    end
  end

  always_comb begin
    pend_nib_d  = pend_nib_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    pend_full_d = pend_full_q;
    act_nib_d   = act_nib_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (w_commit) begin
      act_nib_d   = pend_nib_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = w_lz_mask;
      pend_full_d = 1'b0;
    end
    if (w_xfer) begin
      pend_nib_d  = bcd_in;
      pend_dp_d   = dp_in;
      pend_lz_d   = lz_blank_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_nib_q  <= '0;
      pend_dp_q   <= '0;
      pend_lz_q   <= 1'b0;
      pend_full_q <= 1'b0;
      act_nib_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
    end else begin
      pend_nib_q  <= pend_nib_d;
      pend_dp_q   <= pend_dp_d;
      pend_lz_q   <= pend_lz_d;
      pend_full_q <= pend_full_d;
      act_nib_q   <= act_nib_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = idx_width(BLINK_FRAMES);

  logic [NUM_DIGITS-1:0] pend_blink_q;
  logic [NUM_DIGITS-1:0] act_blink_q;
  logic [BW-1:0]         blink_cnt_q;
  logic                  blink_off_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_blink_q <= '0;
      act_blink_q  <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
    end else begin
      if (w_xfer)
        pend_blink_q <= blink_in;
      if (w_commit)
        act_blink_q <= pend_blink_q;
      if (w_frame_end) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          blink_off_q <= ~blink_off_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_hide = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == IW'(i))
        w_hide = blink_off_q && act_blink_q[i];
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic          w_unused_blink;

  assign w_unused_blink = ^blink_in;
  assign w_hide         = 1'b0;
`endif

  always_comb begin
    w_nib   = 4'd0;
    w_dp    = 1'b0;
    w_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_nib   = act_nib_q[4*(NUM_DIGITS-1-i) +: 4];
        w_dp    = act_dp_q[i];
        w_blank = act_blank_q[i];
      end
    end
  end

  seg_digit_dec #(
    .HEX_MODE (HEX_MODE)
  ) u_dec (
    .nibble_i (w_nib),
    .blank_i  (w_blank),
    .dp_i     (w_dp),
    .code_o   (w_code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_sel_q     <= '1;
      seg_data_q    <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      seg_sel_q     <= w_hide ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_data_q    <= w_hide ? 8'hFF : w_code;
      frame_start_q <= (div_q == '0) && (idx_q == '0);
    end
  end

  assign seg_sel     = seg_sel_q;
  assign seg_data    = seg_data_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_disp_ctrl : directed + random bench for seg_disp_ctrl
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_disp_ctrl;

  localparam int N  = 6;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = N * SD;
`ifdef SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           upd_valid;
  logic           upd_ready, h0_ready;
  logic [4*N-1:0] bcd_in;
  logic [N-1:0]   dp_in, blink_in;
  logic           lz_blank_in;
  logic [N-1:0]   seg_sel, h0_sel;
  logic [7:0]     seg_data, h0_data;
  logic           frame_start, h0_fs;

  always #5 clk = ~clk;

  seg_disp_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_MODE(1), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .bcd_in(bcd_in), .dp_in(dp_in), .lz_blank_in(lz_blank_in), .blink_in(blink_in),
    .seg_sel(seg_sel), .seg_data(seg_data), .frame_start(frame_start));

  seg_disp_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_MODE(0), .BLINK_FRAMES(BF)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(h0_ready),
    .bcd_in(bcd_in), .dp_in(dp_in), .lz_blank_in(lz_blank_in), .blink_in(blink_in),
    .seg_sel(h0_sel), .seg_data(h0_data), .frame_start(h0_fs));

  // Display codes with dp off, straight from the digit table
  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int         errors = 0;
  int         checks = 0;
  int         k;
  bit         m_full, m_xfer, p_lz;
  logic [3:0] p_nib [N];
  bit         p_dp [N], p_blink [N];
  logic [3:0] a_nib [N];
  bit         a_dp [N], a_blank [N], a_blink [N];
  logic [N-1:0] e_sel;
  logic [7:0] e_data, e_data0;
  bit         e_fs, e_ready;

  task automatic model_reset();
    k = 0; m_full = 0; m_xfer = 0;
    for (int d = 0; d < N; d++) begin
      a_nib[d] = 4'd0; a_dp[d] = 0; a_blank[d] = 1; a_blink[d] = 0;
    end
    e_sel = '1; e_data = 8'hFF; e_data0 = 8'hFF; e_fs = 0; e_ready = 1;
  endtask

  // One clock edge of the display: what the edge shows, then what it latches
  task automatic model_edge();
    int d, f;
    bit off, was_full, run;
    logic [7:0] c;
    d   = (k / SD) % N;
    f   = k / FR;
    off = BLINK_ON && (((f / BF) % 2) == 1);
    if (off && a_blink[d]) begin
      e_sel = '1; e_data = 8'hFF; e_data0 = 8'hFF;
    end else begin
      e_sel = '1; e_sel[d] = 1'b0;
      c = tbl[a_nib[d]];
      e_data  = {~a_dp[d], a_blank[d] ? 7'h7F : c[6:0]};
      e_data0 = {~a_dp[d], (a_blank[d] || a_nib[d] > 9) ? 7'h7F : c[6:0]};
    end
    e_fs = (k % FR == 0);
    was_full = m_full;
    m_xfer = 0;
    if ((k % FR == FR - 1) && was_full) begin
      run = p_lz;
      for (int i = 0; i < N; i++) begin
        a_nib[i] = p_nib[i]; a_dp[i] = p_dp[i]; a_blink[i] = p_blink[i];
        if (i < N - 1 && run && p_nib[i] == 4'd0 && !p_dp[i]) a_blank[i] = 1;
        else begin a_blank[i] = 0; run = 0; end
      end
      m_full = 0;
    end
    if (upd_valid && !was_full) begin
      for (int i = 0; i < N; i++) begin
        p_nib[i] = bcd_in[4*(N-1-i) +: 4]; p_dp[i] = dp_in[i]; p_blink[i] = blink_in[i];
      end
      p_lz = lz_blank_in;
      m_full = 1; m_xfer = 1;
    end
    e_ready = !m_full;
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    chk("seg_sel", 32'(seg_sel), 32'(e_sel));
    chk("seg_data", 32'(seg_data), 32'(e_data));
    chk("seg_data_hex0", 32'(h0_data), 32'(e_data0));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("upd_ready", 32'(upd_ready), 32'(e_ready));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [4*N-1:0] b, input logic [N-1:0] dp,
                      input logic lz, input logic [N-1:0] bl);
    bit done;
    bcd_in = b; dp_in = dp; lz_blank_in = lz; blink_in = bl;
    upd_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 3 * FR && !done; i++) begin
      tick();
      done = m_xfer;
    end
    checks++;
    if (!done) begin
      errors++;
      $error("FAIL push_timeout: observed no transfer expected transfer within %0d cycles", 3 * FR);
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; upd_valid = 1'b0; bcd_in = '0; dp_in = '0;
    lz_blank_in = 1'b0; blink_in = '0;
    model_reset();
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    run(2 * FR);

    push(24'h123456, 6'b0, 1'b0, 6'b0);        run(2 * FR);
    push(24'h000705, 6'b0, 1'b1, 6'b0);        run(2 * FR);
    push(24'h000705, 6'b000100, 1'b1, 6'b0);   run(2 * FR);
    push(24'h11AAA1, 6'b0, 1'b0, 6'b0);
    push(24'h654321, 6'b101010, 1'b0, 6'b0);   run(2 * FR);
    push(24'h00000A, 6'b0, 1'b0, 6'b0);        run(2 * FR);
    push(24'h000000, 6'b0, 1'b1, 6'b0);        run(2 * FR);
    push(24'hFEDCBA, 6'b0, 1'b0, 6'b000001);   run(9 * FR);

    // Reset with an update pending and a blinking display
    push(24'h987654, 6'b0, 1'b0, 6'b111111);
    run(5);
    rst_n = 1'b0; run(2); rst_n = 1'b1;
    run(2 * FR);

    for (int r = 0; r < 40; r++) begin
      run($urandom_range(0, 30));
      push(24'($urandom), 6'($urandom), 1'($urandom), 6'($urandom));
    end
    run(6 * FR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
